// File: rtl/npl_cpu_pkg.sv
// npl_cpu_pkg
// Shared definitions for the data-memory port arbiter: datapath widths,
// arbiter FSM state encoding, requester port IDs and memory control codes.
package npl_cpu_pkg;

    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Requester identities; also used as the last-owner encoding
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_EXT = 1'b1;

    // MEM_CTRL encodings
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational winner selection between the CPU port (0) and the external
// loader/debug port (1).
//   req0, req1     : pending requests
//   lock0, lock1   : owner keeps priority while its lock and request are high
//   last_owner     : port that won the previous arbitration
//   valid          : at least one request is pending
//   winner         : selected port (meaningful only when valid)
// Configuration macro MEM_ARB_RR_EN: defined selects round-robin tie breaking,
// undefined selects fixed priority with port 0 winning every tie.
module mem_arb_pick
    import npl_cpu_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

    // A locked owner that is still requesting beats everything; otherwise a
    // tie is broken by the configured policy and a lone request simply wins.
    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (last_owner == PORT_CPU && lock0 && req0) begin
            winner = PORT_CPU;
        end else if (last_owner == PORT_EXT && lock1 && req1) begin
            winner = PORT_EXT;
        end else if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            winner = ~last_owner;
`else
            winner = PORT_CPU;
`endif
        end else if (req1) begin
            winner = PORT_EXT;
        end else begin
            winner = PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-ported 4096 x 32 data memory between the CPU (port 0)
// and a program loader / debug master (port 1). One access at a time:
// arbitration edge -> ACCESS (grant, memory driven) -> RESP (read data
// returned, completion strobe on the following cycle).
//   clk, rst              : rising-edge clock, async active-high reset
//   reqN, wrN, addrN      : request, write enable, word address per port
//   wdataN, lockN         : write data, priority lock per port
//   gntN                  : one-cycle accept pulse (during ACCESS)
//   doneN, rdataN         : one-cycle completion pulse, read data (held)
//   MEM_ADDR, MEM_OUT     : memory address and write data (hold when idle)
//   MEM_CTRL              : 1 = write, only ever high during ACCESS
//   MEM_IN                : memory read data, valid during RESP
// Configuration macro MEM_ARB_RR_EN selects round-robin tie breaking (see
// mem_arb_pick); the default build uses fixed priority for port 0.
module mem_port_arbiter #(
    parameter int WIDTH    = npl_cpu_pkg::WIDTH,
    parameter int ADDRSIZE = npl_cpu_pkg::ADDRSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    input  logic                wr0,
    input  logic                wr1,
    input  logic [ADDRSIZE-1:0] addr0,
    input  logic [ADDRSIZE-1:0] addr1,
    input  logic [0:WIDTH-1]    wdata0,
    input  logic [0:WIDTH-1]    wdata1,
    input  logic                lock0,
    input  logic                lock1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic [0:WIDTH-1]    rdata0,
    output logic [0:WIDTH-1]    rdata1,
    output logic [ADDRSIZE-1:0] MEM_ADDR,
    output logic [0:WIDTH-1]    MEM_OUT,
    output logic                MEM_CTRL,
    input  logic [0:WIDTH-1]    MEM_IN
);

    import npl_cpu_pkg::*;

    arb_state_t          state;
    arb_state_t          state_next;
    logic                owner_q;
    logic                wr_q;
    logic [ADDRSIZE-1:0] addr_q;
    logic [0:WIDTH-1]    wdata_q;
    logic                pick_valid;
    logic                pick_winner;
    logic                arb_window;

    mem_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .lock0      (lock0),
        .lock1      (lock1),
        .last_owner (owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Requests are only looked at in IDLE and RESP; ACCESS ignores them
    assign arb_window = (state == ARB_IDLE) || (state == ARB_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the state-decoded outputs; grant and write strobe are
    // combinational from state so reset kills them immediately.
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        MEM_CTRL   = MEM_RD;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) state_next = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                gnt0       = (owner_q == PORT_CPU);
                gnt1       = (owner_q == PORT_EXT);
                MEM_CTRL   = wr_q;
                state_next = ARB_RESP;
            end
            ARB_RESP: begin
                state_next = pick_valid ? ARB_ACCESS : ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // The latched request doubles as the memory address/data drivers, so
    // MEM_ADDR and MEM_OUT naturally hold between accesses. Completion and
    // read data use the current owner before it is overwritten by a
    // back-to-back arbitration in the same edge. Last owner resets to port 1
    // so port 0 wins the first round-robin tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= PORT_EXT;
            wr_q    <= MEM_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            if (arb_window && pick_valid) begin
                owner_q <= pick_winner;
                wr_q    <= pick_winner ? wr1 : wr0;
                addr_q  <= pick_winner ? addr1 : addr0;
                wdata_q <= pick_winner ? wdata1 : wdata0;
            end
            done0 <= (state == ARB_RESP) && (owner_q == PORT_CPU);
            done1 <= (state == ARB_RESP) && (owner_q == PORT_EXT);
            if (state == ARB_RESP && wr_q == MEM_RD) begin
                if (owner_q == PORT_CPU) rdata0 <= MEM_IN;
                else                     rdata1 <= MEM_IN;
            end
        end
    end

    assign MEM_ADDR = addr_q;
    assign MEM_OUT  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a synchronous 4096 x 32 memory
// behind it. Single transactions come from a vector table; back-to-back,
// arbitration, lock, reset and withdrawn-request cases are hand sequences.
// Honors MEM_ARB_RR_EN for the expected tie-break order.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        wr0 = 1'b0, wr1 = 1'b0;
    logic [11:0] addr0 = '0, addr1 = '0;
    logic [0:31] wdata0 = '0, wdata1 = '0;
    logic        lock0 = 1'b0, lock1 = 1'b0;
    logic        gnt0, gnt1, done0, done1;
    logic [0:31] rdata0, rdata1;
    logic [11:0] mem_addr;
    logic [0:31] mem_out;
    logic        mem_ctrl;
    logic [0:31] mem_in = '0;

    logic [0:31] mem [0:4095];
    logic        preloaded = 1'b0;

    int checks = 0;
    int errors = 0;
    int overlaps = 0;

    typedef struct {
        logic        port;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] last_rd [2];

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .wr0      (wr0),
        .wr1      (wr1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .lock0    (lock0),
        .lock1    (lock1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .MEM_ADDR (mem_addr),
        .MEM_OUT  (mem_out),
        .MEM_CTRL (mem_ctrl),
        .MEM_IN   (mem_in)
    );

    always #5 clk = ~clk;

    // Synchronous memory: registered address, data out the following cycle
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem[5]    <= 32'h1234_5678;
            preloaded <= 1'b1;
        end else if (mem_ctrl) begin
            mem[mem_addr] <= mem_out;
        end
        mem_in <= mem[mem_addr];
    end

    // Grants and completions must never overlap between ports
    always @(negedge clk) begin
        if ((gnt0 && gnt1) || (done0 && done1)) overlaps++;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    // One isolated transaction starting from IDLE at a negedge
    task automatic apply_stimulus(input vec_t v);
        if (v.port) begin
            req1 = 1'b1; wr1 = v.wr; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; wr0 = v.wr; addr0 = v.addr; wdata0 = v.wdata;
        end
        @(negedge clk);
        check_output("vec gnt own",   32'(v.port ? gnt1 : gnt0), 32'd1);
        check_output("vec gnt other", 32'(v.port ? gnt0 : gnt1), 32'd0);
        check_output("vec mem_addr",  32'(mem_addr), 32'(v.addr));
        check_output("vec mem_ctrl",  32'(mem_ctrl), 32'(v.wr));
        if (v.wr) check_output("vec mem_out", mem_out, v.wdata);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check_output("vec resp ctrl", 32'(mem_ctrl), 32'd0);
        check_output("vec resp done", 32'(done0 | done1), 32'd0);
        @(negedge clk);
        check_output("vec done own",   32'(v.port ? done1 : done0), 32'd1);
        check_output("vec done other", 32'(v.port ? done0 : done1), 32'd0);
        if (!v.wr) last_rd[v.port] = v.exp_rdata;
        check_output("vec rdata", v.port ? rdata1 : rdata0, last_rd[v.port]);
        @(negedge clk);
        check_output("vec done end", 32'(done0 | done1), 32'd0);
        check_output("vec idle gnt", 32'(gnt0 | gnt1), 32'd0);
    endtask

    initial begin
        logic        order [4];
        logic        exp_order [4];
        int          got;
        int          ctrl_hi;
        int          bad;

        vecs[0] = '{1'b0, 1'b0, 12'h005, 32'h0000_0000, 32'h1234_5678};
        vecs[1] = '{1'b1, 1'b1, 12'hFFF, 32'h0BAD_F00D, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 12'hFFF, 32'h0000_0000, 32'h0BAD_F00D};
        vecs[3] = '{1'b0, 1'b1, 12'h000, 32'hA5A5_0F0F, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 32'hA5A5_0F0F};
        vecs[5] = '{1'b1, 1'b0, 12'h005, 32'h0000_0000, 32'h1234_5678};
        vecs[6] = '{1'b0, 1'b0, 12'hFFF, 32'h0000_0000, 32'h0BAD_F00D};
        vecs[7] = '{1'b1, 1'b1, 12'h800, 32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{1'b0, 1'b0, 12'h800, 32'h0000_0000, 32'h0000_0001};

        // Reset state
        repeat (2) @(negedge clk);
        check_output("reset gnt",   32'({gnt0, gnt1}), 32'd0);
        check_output("reset done",  32'({done0, done1}), 32'd0);
        check_output("reset ctrl",  32'(mem_ctrl), 32'd0);
        check_output("reset addr",  32'(mem_addr), 32'd0);
        check_output("reset out",   mem_out, 32'd0);
        check_output("reset rdata", rdata0 | rdata1, 32'd0);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

        // Port 1 write then read, back-to-back
        ctrl_hi = 0;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 12'hFFF; wdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        check_output("b2b wr gnt", 32'(gnt1), 32'd1);
        check_output("b2b wr out", mem_out, 32'hDEAD_BEEF);
        if (mem_ctrl) ctrl_hi++;
        wr1 = 1'b0;
        @(negedge clk);
        if (mem_ctrl) ctrl_hi++;
        @(negedge clk);
        if (mem_ctrl) ctrl_hi++;
        check_output("b2b wr done", 32'(done1), 32'd1);
        check_output("b2b rd gnt",  32'(gnt1), 32'd1);
        check_output("b2b rd addr", 32'(mem_addr), 32'hFFF);
        req1 = 1'b0;
        @(negedge clk);
        if (mem_ctrl) ctrl_hi++;
        check_output("b2b gap done", 32'(done1), 32'd0);
        @(negedge clk);
        if (mem_ctrl) ctrl_hi++;
        check_output("b2b rd done",  32'(done1), 32'd1);
        check_output("b2b rd data",  rdata1, 32'hDEAD_BEEF);
        @(negedge clk);
        check_output("b2b ctrl cycles", 32'(ctrl_hi), 32'd1);
        check_output("b2b done end", 32'(done1), 32'd0);
        drain();

        // Simultaneous requests held for four grants
`ifdef MEM_ARB_RR_EN
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
`else
        exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0; exp_order[3] = 1'b0;
`endif
        reset_dut();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h005;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'hFFF;
        got = 0;
        for (int cyc = 0; cyc < 16 && got < 4; cyc++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                order[got] = gnt1;
                got++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check_output("tie grant count", 32'(got), 32'd4);
        for (int i = 0; i < 4; i++)
            check_output($sformatf("tie grant %0d", i), 32'(order[i]), 32'(exp_order[i]));
        drain();

        // Lock held by port 1 against a competing port 0
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h005; lock1 = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 24 && got < 4; cyc++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                order[got] = gnt1;
                got++;
                if (got == 1) begin
                    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'hFFF;
                end
                if (got == 3) lock1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        lock1 = 1'b0;
        check_output("lock grant count", 32'(got), 32'd4);
        check_output("lock grant 0", 32'(order[0]), 32'd1);
        check_output("lock grant 1", 32'(order[1]), 32'd1);
        check_output("lock grant 2", 32'(order[2]), 32'd1);
        check_output("lock release", 32'(order[3]), 32'd0);
        drain();

        // Reset asserted during the ACCESS cycle of a write
        req0 = 1'b1; wr0 = 1'b1; addr0 = 12'h123; wdata0 = 32'h55AA_55AA;
        @(negedge clk);
        check_output("rst pre ctrl", 32'(mem_ctrl), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_output("rst ctrl",  32'(mem_ctrl), 32'd0);
        check_output("rst gnt",   32'({gnt0, gnt1}), 32'd0);
        check_output("rst done",  32'({done0, done1}), 32'd0);
        check_output("rst addr",  32'(mem_addr), 32'd0);
        check_output("rst out",   mem_out, 32'd0);
        check_output("rst rdata", rdata0 | rdata1, 32'd0);
        req0 = 1'b0;
        wr0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 | done1 | gnt0 | gnt1) bad++;
        end
        check_output("rst no activity", 32'(bad), 32'd0);
        check_output("rst no write", mem[12'h123], 32'd0);
        req0 = 1'b1; addr0 = 12'h005;
        req1 = 1'b1; addr1 = 12'hFFF;
        @(negedge clk);
        check_output("rst tie gnt0", 32'(gnt0), 32'd1);
        check_output("rst tie gnt1", 32'(gnt1), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        drain();

        // Request withdrawn before the arbitration edge
        req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h005;
        #2 req1 = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (gnt0 | gnt1 | done1) bad++;
        end
        check_output("withdrawn", 32'(bad), 32'd0);

        check_output("port overlap", 32'(overlaps), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
